fib_stack_engine: RTL and testbench
===================================

# fib_stack_engine

Parametrised Fibonacci engine that evaluates fib(n) by explicit-stack expansion of the recursive call tree, with the operand stack integrated in the block. Generalises the fixed-width stack controller: configurable operand, result and call-counter widths and stack depth, plus a start/busy/done handshake, stack-overflow abort, and saturating result/call counters. Sits between the board input registers (n, start button) and the display driver.

## Interface
- N_W, 6, width of operand n
- RES_W, 16, width of result
- CNT_W, 16, width of call counter
- DEPTH, 32, stack entries (≥2); SP_W = clog2(DEPTH+1)
- clk  in  1  rising-edge clock
- CLR  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- n  in  N_W  operand; sampled on the accepting edge only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high while in DONE
- err  out  1  stack overflow abort; sticky until next accepted start
- ovf  out  1  result saturated; sticky until next accepted start
- result  out  RES_W  fib(n), or saturated or partial value
- calls  out  CNT_W  number of pops (tree nodes visited), saturating

## Operation
- Stack: DEPTH×N_W register array, pointer sp (0..DEPTH). Array contents not reset; sp is.
- States: IDLE, POP, PUSH1, PUSH2, DONE, ERR.
- IDLE: start=1 → stack[0]=n, sp=1, result=0, calls=0, err=0, ovf=0; → POP.
- POP: sp==0 → DONE. Else pop x=stack[sp-1], sp−1, calls+1 (saturate at 2^CNT_W−1).
  - x<2: result+=x; on carry out, result=2^RES_W−1 and ovf=1; stay POP.
  - x≥2: t=x; → PUSH1.
- PUSH1: sp==DEPTH → ERR; else push t−1 → PUSH2.
- PUSH2: sp==DEPTH → ERR; else push t−2 → POP.
- DONE: done=1; → IDLE.
- ERR: err=1, done=1 for this cycle; → IDLE. result and calls keep their partial values.
- Push order: t−1 then t−2, so the smaller operand is on top. Peak sp = floor(n/2)+1 for n≥1, and 1 for n=0.
- result, calls, ovf, err hold after DONE/ERR until the next accepted start.
- start while busy: ignored, with no effect on any state.

## Timing
- Reset (CLR=0, any time, including mid-run): state=IDLE, sp=0, busy=done=err=ovf=0, result=0, calls=0. The run is lost. The first accepted start after deassertion begins a fresh run.
- Accepting edge E0. busy=1 from E0.
- Let L = leaves and I = internal nodes. The FSM enters DONE at edge E0+3I+L+1. done is high for the one cycle that follows. IDLE is re-entered on the next edge, with busy=0.
- Cost per node: leaf 1 cycle; internal node 3 cycles (POP, PUSH1, PUSH2); final empty check 1 cycle.
- For n, calls = 2·fib(n+1)−1.
- All outputs are registered or decoded from state. There is no combinational path from start or n to any output.
- start may be held high: a new run is accepted on the IDLE edge that follows DONE.

## Test plan
- Reset mid-run: n=10 start, assert CLR=0 on cycle 5 → immediately busy=0, result=0, calls=0, sp=0; after release, n=3 start → result=2.
- Small operands, defaults: n=0 → done at E0+2, result=0, calls=1. n=1 → done at E0+2, result=1, calls=1. n=2 → done at E0+6, result=1, calls=3.
- Mid operand: n=5 → done at E0+30, result=5, calls=15, err=0, ovf=0. Check that busy stays high throughout, and that a start pulse at cycle 10 is ignored.
- Saturation: RES_W=8, n=14 → result=255, ovf=1, err=0, calls=1219. Check that ovf clears on the next start.
- Overflow abort: DEPTH=2, n=4 → ERR on the PUSH2 of node 2 (sp==2). done and err pulse/assert, calls=2, result=0. err stays high until the next start.
- Back-to-back: start held high with n=6 → two runs, each result=8, calls=25. busy drops for exactly one IDLE cycle between the runs.

Source files
------------

// File: rtl/fib_stack_engine_if.sv
// Handshake and result bus between the board input registers / display driver
// (master side) and the Fibonacci stack engine (slave side).
interface fib_stack_engine_if #(
  parameter int N_W   = 6,
  parameter int RES_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic             err;
  logic             ovf;
  logic [RES_W-1:0] result;
  logic [CNT_W-1:0] calls;

  modport master (
    output start, n,
    input  busy, done, err, ovf, result, calls
  );

  modport slave (
    input  start, n,
    output busy, done, err, ovf, result, calls
  );
endinterface

// File: rtl/fib_stack_engine.sv
// Fibonacci engine: evaluates fib(n) by expanding the recursive call tree on an
// explicit operand stack. Leaves (x<2) add x into the result; internal nodes
// push x-1 then x-2 so the smaller operand is processed first, keeping the
// peak stack depth at floor(n/2)+1.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last run's values
// POP   | stack empty -> DONE, else pop one node and count it
// PUSH1 | push t-1 (abort to ERR if stack full)
// PUSH2 | push t-2 (abort to ERR if stack full)
// DONE  | one-cycle completion pulse
// ERR   | one-cycle completion pulse after a stack overflow abort
module fib_stack_engine #(
  parameter int N_W   = 6,
  parameter int RES_W = 16,
  parameter int CNT_W = 16,
  parameter int DEPTH = 32
) (
  input  logic                clk,
  input  logic                CLR,
  fib_stack_engine_if.slave   bus
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    PUSH1 = 3'd2,
    PUSH2 = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t           state_q;
  logic [SP_W-1:0]  sp_q;
  logic [N_W-1:0]   t_q;
  logic [RES_W-1:0] result_q;
  logic [CNT_W-1:0] calls_q;
  logic             err_q;
  logic             ovf_q;

  // Operand storage is deliberately not reset; only the pointer is.
  logic [N_W-1:0]   stack_q [DEPTH];

  logic             full;
  logic             empty;
  logic [AW-1:0]    rd_idx;
  logic [N_W-1:0]   top;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [N_W-1:0]   wr_data;

  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign rd_idx = AW'(sp_q - SP_W'(1));
  assign top    = stack_q[rd_idx];

  // Stack write port: seed on an accepted start, children on the push states.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = AW'(sp_q);
    wr_data = bus.n;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          wr_en  = 1'b1;
          wr_idx = '0;
        end
      end
      PUSH1: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_data = t_q - N_W'(1);
        end
      end
      PUSH2: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_data = t_q - N_W'(2);
        end
      end
      default: ;
    endcase
  end

  // Stack array update.
  always_ff @(posedge clk) begin
    if (wr_en) stack_q[wr_idx] <= wr_data;
  end

  // Main sequencer with pointer, result, call counter and sticky flags.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      sp_q     <= '0;
      t_q      <= '0;
      result_q <= '0;
      calls_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sp_q     <= SP_W'(1);
            result_q <= '0;
            calls_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= POP;
          end
        end
        POP: begin
          if (empty) begin
            state_q <= DONE;
          end else begin
            sp_q <= sp_q - SP_W'(1);
            if (calls_q != '1) calls_q <= calls_q + CNT_W'(1);
            if (top < N_W'(2)) begin
              // Leaf: only x==1 contributes; saturate instead of wrapping.
              if (top == N_W'(1)) begin
                if (&result_q) ovf_q    <= 1'b1;
                else           result_q <= result_q + RES_W'(1);
              end
            end else begin
              t_q     <= top;
              state_q <= PUSH1;
            end
          end
        end
        PUSH1: begin
          if (full) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            sp_q    <= sp_q + SP_W'(1);
            state_q <= PUSH2;
          end
        end
        PUSH2: begin
          if (full) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            sp_q    <= sp_q + SP_W'(1);
            state_q <= POP;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE) || (state_q == ERR);
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;
  assign bus.result = result_q;
  assign bus.calls  = calls_q;

endmodule

// File: tb/tb_fib_stack_engine.sv
// Bench for fib_stack_engine: three instances (defaults, 8-bit result,
// depth-2 stack) sharing clock and reset; expectations go into a scoreboard
// queue when a run is launched and are popped when done is seen.
module tb_fib_stack_engine;

  logic clk = 1'b0;
  logic CLR = 1'b0;
  always #5 clk = ~clk;

  fib_stack_engine_if #(.N_W(6), .RES_W(16), .CNT_W(16)) if_def ();
  fib_stack_engine_if #(.N_W(6), .RES_W(8),  .CNT_W(16)) if_sat ();
  fib_stack_engine_if #(.N_W(6), .RES_W(16), .CNT_W(16)) if_dep ();

  fib_stack_engine #(.N_W(6), .RES_W(16), .CNT_W(16), .DEPTH(32)) u_def (
    .clk(clk), .CLR(CLR), .bus(if_def));
  fib_stack_engine #(.N_W(6), .RES_W(8),  .CNT_W(16), .DEPTH(32)) u_sat (
    .clk(clk), .CLR(CLR), .bus(if_sat));
  fib_stack_engine #(.N_W(6), .RES_W(16), .CNT_W(16), .DEPTH(2))  u_dep (
    .clk(clk), .CLR(CLR), .bus(if_dep));

  typedef struct {
    int res;
    int calls;
    int lat;
    bit err;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam int W_DEF = 0;
  localparam int W_SAT = 1;
  localparam int W_DEP = 2;

  function automatic int fib(input int k);
    int a = 0, b = 1, t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference model for a run that completes without stack overflow.
  function automatic exp_t model(input int nv, input int res_max);
    exp_t e;
    int   leaves;
    leaves  = fib(nv + 1);
    e.res   = (fib(nv) > res_max) ? res_max : fib(nv);
    e.ovf   = (fib(nv) > res_max);
    e.calls = 2 * leaves - 1;
    e.lat   = 3 * (leaves - 1) + leaves + 1;
    e.err   = 1'b0;
    return e;
  endfunction

  task automatic set_start(input int w, input logic v, input int nv);
    case (w)
      W_DEF:   begin if_def.start = v; if_def.n = 6'(nv); end
      W_SAT:   begin if_sat.start = v; if_sat.n = 6'(nv); end
      default: begin if_dep.start = v; if_dep.n = 6'(nv); end
    endcase
  endtask

  task automatic sample(input int w, output logic d, output logic b,
                        output logic e, output logic o,
                        output int r, output int c);
    case (w)
      W_DEF: begin
        d = if_def.done; b = if_def.busy; e = if_def.err; o = if_def.ovf;
        r = int'(if_def.result); c = int'(if_def.calls);
      end
      W_SAT: begin
        d = if_sat.done; b = if_sat.busy; e = if_sat.err; o = if_sat.ovf;
        r = int'(if_sat.result); c = int'(if_sat.calls);
      end
      default: begin
        d = if_dep.done; b = if_dep.busy; e = if_dep.err; o = if_dep.ovf;
        r = int'(if_dep.result); c = int'(if_dep.calls);
      end
    endcase
  endtask

  // Drive start for one accepting edge; returns #1 after edge E0.
  task automatic launch(input int w, input int nv);
    set_start(w, 1'b1, nv);
    @(posedge clk); #1;
    set_start(w, 1'b0, nv);
  endtask

  // Counts edges after E0 until done; optionally pokes start mid-run.
  task automatic wait_done(input int w, input int pulse_at, output int lat,
                           output bit busy_bad);
    logic d, b, e, o;
    int   r, c;
    lat      = -1;
    busy_bad = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      if (k == pulse_at + 1) set_start(w, 1'b0, 0);
      @(posedge clk); #1;
      if (k == pulse_at) set_start(w, 1'b1, 9);
      sample(w, d, b, e, o, r, c);
      if (b !== 1'b1) busy_bad = 1'b1;
      if (d === 1'b1) begin
        lat = k;
        break;
      end
    end
    set_start(w, 1'b0, 0);
  endtask

  // Pops the scoreboard and compares against the DUT outputs in the done cycle.
  task automatic check_run(input int w, input string tag, input int lat);
    logic d, b, e, o;
    int   r, c;
    exp_t x;
    sample(w, d, b, e, o, r, c);
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: no expectation queued", tag);
      return;
    end
    n_pass++;
    x = sb.pop_front();
    n_total++;
    if (lat !== x.lat) $display("FAIL %s latency: got %0d expected %0d", tag, lat, x.lat);
    else n_pass++;
    n_total++;
    if (r !== x.res) $display("FAIL %s result: got %0d expected %0d", tag, r, x.res);
    else n_pass++;
    n_total++;
    if (c !== x.calls) $display("FAIL %s calls: got %0d expected %0d", tag, c, x.calls);
    else n_pass++;
    n_total++;
    if ({e, o} !== {x.err, x.ovf})
      $display("FAIL %s err/ovf: got %b%b expected %b%b", tag, e, o, x.err, x.ovf);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic d, b, e, o;
    int   r, c;
    #12;
    for (int w = 0; w < 3; w++) begin
      sample(w, d, b, e, o, r, c);
      n_total++;
      if ({d, b, e, o} !== 4'b0000 || r !== 0 || c !== 0)
        $display("FAIL reset_state[%0d]: got done/busy/err/ovf=%b%b%b%b result=%0d calls=%0d expected 0000 0 0",
                 w, d, b, e, o, r, c);
      else n_pass++;
    end
    CLR = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    logic d, b, e, o;
    int   r, c, lat;
    bit   bb;
    launch(W_DEF, 10);
    repeat (4) begin @(posedge clk); #1; end
    CLR = 1'b0;
    #1;
    sample(W_DEF, d, b, e, o, r, c);
    n_total++;
    if ({d, b} !== 2'b00 || r !== 0 || c !== 0)
      $display("FAIL midrun_reset: got busy=%b done=%b result=%0d calls=%0d expected 0 0 0 0",
               b, d, r, c);
    else n_pass++;
    #2;
    CLR = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(3, 65535));
    launch(W_DEF, 3);
    wait_done(W_DEF, -1, lat, bb);
    check_run(W_DEF, "after_reset_n3", lat);
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    int lat;
    bit bb;
    for (int nv = 0; nv <= 2; nv++) begin
      sb.push_back(model(nv, 65535));
      launch(W_DEF, nv);
      wait_done(W_DEF, -1, lat, bb);
      check_run(W_DEF, $sformatf("small_n%0d", nv), lat);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid();
    logic d, b, e, o;
    int   r, c, lat;
    bit   bb;
    sb.push_back(model(5, 65535));
    launch(W_DEF, 5);
    wait_done(W_DEF, 10, lat, bb);
    check_run(W_DEF, "mid_n5", lat);
    n_total++;
    if (bb) $display("FAIL mid_busy: got busy low during run expected high throughout");
    else n_pass++;
    @(posedge clk); #1;
    sample(W_DEF, d, b, e, o, r, c);
    n_total++;
    if ({b, d} !== 2'b00 || r !== 5)
      $display("FAIL mid_idle: got busy=%b done=%b result=%0d expected 0 0 5", b, d, r);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic d, b, e, o;
    int   r, c, lat;
    bit   bb;
    sb.push_back(model(14, 255));
    launch(W_SAT, 14);
    wait_done(W_SAT, -1, lat, bb);
    check_run(W_SAT, "sat_n14", lat);
    @(posedge clk); #1;
    sample(W_SAT, d, b, e, o, r, c);
    n_total++;
    if (o !== 1'b1 || r !== 255)
      $display("FAIL sat_hold: got ovf=%b result=%0d expected 1 255", o, r);
    else n_pass++;
    sb.push_back(model(3, 255));
    launch(W_SAT, 3);
    sample(W_SAT, d, b, e, o, r, c);
    n_total++;
    if (o !== 1'b0) $display("FAIL sat_ovf_clear: got ovf=%b expected 0", o);
    else n_pass++;
    wait_done(W_SAT, -1, lat, bb);
    check_run(W_SAT, "sat_n3", lat);
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic d, b, e, o;
    int   r, c, lat;
    bit   bb;
    exp_t x;
    x.res = 0; x.calls = 2; x.lat = 6; x.err = 1'b1; x.ovf = 1'b0;
    sb.push_back(x);
    launch(W_DEP, 4);
    wait_done(W_DEP, -1, lat, bb);
    check_run(W_DEP, "abort_n4", lat);
    repeat (3) begin @(posedge clk); #1; end
    sample(W_DEP, d, b, e, o, r, c);
    n_total++;
    if ({e, b, d} !== 3'b100 || c !== 2)
      $display("FAIL abort_sticky: got err=%b busy=%b done=%b calls=%0d expected 1 0 0 2",
               e, b, d, c);
    else n_pass++;
    sb.push_back(model(1, 65535));
    launch(W_DEP, 1);
    sample(W_DEP, d, b, e, o, r, c);
    n_total++;
    if (e !== 1'b0) $display("FAIL abort_err_clear: got err=%b expected 0", e);
    else n_pass++;
    wait_done(W_DEP, -1, lat, bb);
    check_run(W_DEP, "dep_n1", lat);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic d, b, e, o;
    int   r, c, lat;
    bit   bb;
    int   idle_cycles;
    sb.push_back(model(6, 65535));
    sb.push_back(model(6, 65535));
    set_start(W_DEF, 1'b1, 6);
    @(posedge clk); #1;
    // start stays high so the run after DONE is also accepted
    lat = -1;
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk); #1;
      sample(W_DEF, d, b, e, o, r, c);
      if (d === 1'b1) begin lat = k; break; end
    end
    check_run(W_DEF, "b2b_run1", lat);
    idle_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      sample(W_DEF, d, b, e, o, r, c);
      if (b === 1'b1) break;
      idle_cycles++;
    end
    set_start(W_DEF, 1'b0, 6);
    n_total++;
    if (idle_cycles !== 1)
      $display("FAIL b2b_idle_gap: got %0d idle cycles expected 1", idle_cycles);
    else n_pass++;
    wait_done(W_DEF, -1, lat, bb);
    check_run(W_DEF, "b2b_run2", lat);
    repeat (2) begin @(posedge clk); #1; end
    sample(W_DEF, d, b, e, o, r, c);
    n_total++;
    if (b !== 1'b0 || r !== 8)
      $display("FAIL b2b_stop: got busy=%b result=%0d expected 0 8", b, r);
    else n_pass++;
  endtask

  initial begin
    set_start(W_DEF, 1'b0, 0);
    set_start(W_SAT, 1'b0, 0);
    set_start(W_DEP, 1'b0, 0);
    test_reset();
    test_reset_midrun();
    test_small();
    test_mid();
    test_saturation();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
